// File: rtl/heartbeat_pattern_gen_if.sv
// Mode-code input and heartbeat outputs of heartbeat_pattern_gen.
// The slave modport is the generator; the master modport is whatever supplies mode codes.
interface heartbeat_pattern_gen_if;
    logic [3:0] mode_in;
    logic       led;
    logic       beat;
    logic [3:0] cur_mode;
    logic       err;

    modport master (output mode_in, input led, beat, cur_mode, err);
    modport slave  (input mode_in, output led, beat, cur_mode, err);
endinterface

// File: rtl/heartbeat_pattern_gen.sv
// Lub-dub heartbeat LED generator with a ms-tick timebase, a PWM-dimmed DUB pulse,
// a 1-cycle beat strobe, and a fixed error blink selected by mode code F.
module heartbeat_pattern_gen #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned PULSE_MS = 100,
    parameter int unsigned PERIOD1  = 1000,
    parameter int unsigned PERIOD2  = 750,
    parameter int unsigned PERIOD3  = 500,
    parameter int unsigned PERIOD4  = 375,
    parameter int unsigned ERR_HALF = 250,
    parameter int unsigned DUB_DUTY = 128
) (
    input logic               clk,
    input logic               rst_n,
    heartbeat_pattern_gen_if.slave bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned period_of(input int unsigned idx);
        case (idx)
            0:       return PERIOD1;
            1:       return PERIOD2;
            2:       return PERIOD3;
            default: return PERIOD4;
        endcase
    endfunction

    localparam int unsigned MS_MAX = max2(max2(max2(PERIOD1, PERIOD2), max2(PERIOD3, PERIOD4)),
                                          max2(ERR_HALF, PULSE_MS));
    localparam int unsigned MS_W   = $clog2(MS_MAX + 1);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [MS_W-1:0] REST1_LAST = MS_W'(PERIOD1 - 3 * PULSE_MS - 1);

    typedef enum logic [2:0] {REST, LUB, GAP, DUB, ERR_ON, ERR_OFF} state_t;

    state_t            state_reg;
    logic [MS_W-1:0]   ms_cnt_reg;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic [7:0]        pwm_cnt_reg;
    logic [3:0]        pending_mode_reg;
    logic [3:0]        cur_mode_reg;
    logic              led_reg;
    logic              beat_reg;
    logic              err_reg;
    logic              resume_reg;

    // Last ms_cnt value of REST for each mode (REST_LEN - 1).
    logic [MS_W-1:0] rest_last_tbl [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_rest_last
        assign rest_last_tbl[gi] = MS_W'(period_of(gi) - 3 * PULSE_MS - 1);
    end

    logic            tick;
    logic            mode_valid;
    logic            mode_err;
    logic [1:0]      mode_idx;
    logic [1:0]      cur_idx;
    logic [MS_W-1:0] dur_last;
    logic            ms_done;
    logic            led_next;

    assign tick       = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));
    assign mode_valid = (bus.mode_in != 4'd0) && (bus.mode_in <= 4'd4);
    assign mode_err   = (bus.mode_in == 4'hF);
    assign mode_idx   = 2'(bus.mode_in - 4'd1);
    assign cur_idx    = 2'(cur_mode_reg - 4'd1);
    assign ms_done    = (ms_cnt_reg == dur_last);

    always_comb begin
        dur_last = MS_W'(PULSE_MS - 1);
        case (state_reg)
            REST:            dur_last = rest_last_tbl[cur_idx];
            ERR_ON, ERR_OFF: dur_last = MS_W'(ERR_HALF - 1);
            default:         ;
        endcase
    end

    always_comb begin
        led_next = 1'b0;
        case (state_reg)
            LUB, ERR_ON: led_next = 1'b1;
            DUB:         led_next = (32'(pwm_cnt_reg) < DUB_DUTY);
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= REST;
            ms_cnt_reg       <= REST1_LAST;
            tick_cnt_reg     <= '0;
            pwm_cnt_reg      <= '0;
            pending_mode_reg <= 4'h1;
            cur_mode_reg     <= 4'h1;
            led_reg          <= 1'b0;
            beat_reg         <= 1'b0;
            err_reg          <= 1'b0;
            resume_reg       <= 1'b0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
            pwm_cnt_reg  <= pwm_cnt_reg + 8'd1;
            led_reg      <= led_next;
            beat_reg     <= 1'b0;
            if (mode_valid) begin
                pending_mode_reg <= bus.mode_in;
            end
            case (state_reg)
                REST, LUB, GAP, DUB: begin
                    if (mode_err) begin
                        state_reg  <= ERR_ON;
                        ms_cnt_reg <= '0;
                        err_reg    <= 1'b1;
                        resume_reg <= 1'b0;
                    end else if (tick) begin
                        // Returning from error, the first tick always starts a beat.
                        if (state_reg == REST && (resume_reg || ms_done)) begin
                            state_reg    <= LUB;
                            ms_cnt_reg   <= '0;
                            cur_mode_reg <= pending_mode_reg;
                            beat_reg     <= 1'b1;
                            resume_reg   <= 1'b0;
                        end else if (ms_done) begin
                            ms_cnt_reg <= '0;
                            case (state_reg)
                                LUB:     state_reg <= GAP;
                                GAP:     state_reg <= DUB;
                                default: state_reg <= REST;
                            endcase
                        end else begin
                            ms_cnt_reg <= ms_cnt_reg + 1'b1;
                        end
                    end
                end
                ERR_ON, ERR_OFF: begin
                    if (mode_valid) begin
                        state_reg  <= REST;
                        ms_cnt_reg <= rest_last_tbl[mode_idx];
                        err_reg    <= 1'b0;
                        resume_reg <= 1'b1;
                    end else if (tick) begin
                        if (ms_done) begin
                            ms_cnt_reg <= '0;
                            state_reg  <= (state_reg == ERR_ON) ? ERR_OFF : ERR_ON;
                        end else begin
                            ms_cnt_reg <= ms_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= REST;
            endcase
        end
    end

    assign bus.led      = led_reg;
    assign bus.beat     = beat_reg;
    assign bus.cur_mode = cur_mode_reg;
    assign bus.err      = err_reg;

endmodule

// File: tb/tb_heartbeat_pattern_gen.sv
// Randomized directed bench for heartbeat_pattern_gen; expectations come from a
// beat-position/error-tick arithmetic model of the heartbeat timing.
module tb_heartbeat_pattern_gen;

    localparam int unsigned TD = 4;
    localparam int unsigned PM = 3;
    localparam int unsigned P1 = 20;
    localparam int unsigned P2 = 16;
    localparam int unsigned P3 = 12;
    localparam int unsigned P4 = 10;
    localparam int unsigned EH = 5;
    localparam int unsigned DD = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    heartbeat_pattern_gen_if bus ();

    heartbeat_pattern_gen #(
        .TICK_DIV(TD), .PULSE_MS(PM),
        .PERIOD1(P1), .PERIOD2(P2), .PERIOD3(P3), .PERIOD4(P4),
        .ERR_HALF(EH), .DUB_DUTY(DD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: edges since reset, tick position inside the beat cycle, error ticks.
    int         k;
    int         pos;
    int         eticks;
    bit         m_err;
    logic [3:0] m_cur;
    logic [3:0] m_pend;
    int         beats;

    function automatic int per(input logic [3:0] m);
        case (m)
            4'd2:    return P2;
            4'd3:    return P3;
            4'd4:    return P4;
            default: return P1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        pos    = per(4'd1) - 1;
        eticks = 0;
        m_err  = 1'b0;
        m_cur  = 4'd1;
        m_pend = 4'd1;
    endtask

    // Apply one mode code for one clock, then compare all outputs against the model.
    task automatic step(input logic [3:0] m);
        logic exp_led;
        logic exp_beat;
        bit   tick;
        bit   valid;
        int   seg;
        bus.mode_in = m;
        @(posedge clk);
        #1;
        k++;
        tick  = (k % TD == 0);
        valid = (m >= 4'd1 && m <= 4'd4);
        if (m_err) begin
            exp_led = ((eticks / EH) % 2 == 0);
        end else begin
            seg = pos / PM;
            if (seg == 0)      exp_led = 1'b1;
            else if (seg == 2) exp_led = (((k - 1) % 256) < DD);
            else               exp_led = 1'b0;
        end
        exp_beat = 1'b0;
        if (!m_err) begin
            if (m == 4'hF) begin
                m_err  = 1'b1;
                eticks = 0;
            end else if (tick) begin
                if (pos == per(m_cur) - 1) begin
                    pos      = 0;
                    m_cur    = m_pend;
                    exp_beat = 1'b1;
                end else begin
                    pos++;
                end
            end
        end else begin
            if (valid) begin
                m_err = 1'b0;
                pos   = per(m_cur) - 1;
            end else if (tick) begin
                eticks++;
            end
        end
        if (valid) m_pend = m;
        if (exp_beat) beats++;
        check("led", 32'(bus.led), 32'(exp_led));
        check("beat", 32'(bus.beat), 32'(exp_beat));
        check("cur_mode", 32'(bus.cur_mode), 32'(m_cur));
        check("err", 32'(bus.err), 32'(m_err));
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_led"}, 32'(bus.led), 32'd0);
        check({tag, "_beat"}, 32'(bus.beat), 32'd0);
        check({tag, "_cur_mode"}, 32'(bus.cur_mode), 32'd1);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("reset %s applied and released", tag);
    endtask

    initial begin
        logic [3:0] m;
        logic [3:0] v;
        bit         ok;
        bus.mode_in = 4'd1;
        model_reset();
        beats = 0;
        #23;
        @(negedge clk);
        rst_n = 1'b1;
        check("por_cur_mode", 32'(bus.cur_mode), 32'd1);
        check("por_led", 32'(bus.led), 32'd0);

        // Mode 1 held: beats at edges 4, 84, 164.
        repeat (200) step(4'd1);
        check("beats_mode1", 32'(beats), 32'd3);
        $display("mode1 run: beats=%0d", beats);

        // Switch to mode 3 while in GAP.
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step(4'd1);
            ok = !m_err && (pos / PM == 1);
        end
        check("reach_gap", 32'(ok), 32'd1);
        repeat (200) step(4'd3);
        $display("mode3 run: cur_mode=%0d", bus.cur_mode);

        // Error entered during DUB, then recovery with mode 4.
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step(4'd3);
            ok = !m_err && (pos / PM == 2);
        end
        check("reach_dub", 32'(ok), 32'd1);
        beats = 0;
        repeat (60) step(4'hF);
        check("no_beats_in_err", 32'(beats), 32'd0);
        repeat (120) step(4'd4);
        $display("error blink then mode4: cur_mode=%0d", bus.cur_mode);

        // Mode 2 with ignored codes sprinkled in.
        repeat (40) step(4'd2);
        for (int i = 0; i < 200; i++) begin
            v = 4'($urandom_range(4, 14));
            if (v == 4'd4) v = 4'd0;
            step(v);
        end
        check("mode2_sticky", 32'(bus.cur_mode), 32'd2);
        $display("mode2 with ignored codes: cur_mode=%0d", bus.cur_mode);

        // Random walk over all codes.
        m = 4'd1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) m = 4'($urandom_range(0, 15));
            step(m);
        end
        $display("random walk done: checks=%0d", checks);

        // Reset mid-LUB.
        beats = 0;
        for (int i = 0; i < 300 && beats == 0; i++) step(4'd1);
        check("found_beat", 32'(beats != 0), 32'd1);
        repeat (3) step(4'd1);
        async_reset("mid_lub");
        repeat (100) step(4'd1);

        // Reset while in ERR_ON.
        repeat (10) step(4'hF);
        async_reset("err_on");
        beats = 0;
        repeat (100) step(4'd1);
        check("beats_after_reset", 32'(beats), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/heartbeat_pattern_gen.md
Name: heartbeat_pattern_gen

Overview:
- Consumer of the 4-bit mode code produced by the button-latch block. Codes 1..4 select a heartbeat rate; code F flags a multi-key error.
- Generates a "lub-dub" LED waveform from a ms-tick timebase. The DUB pulse is dimmed by PWM, and a 1-cycle beat strobe is produced for downstream display logic.
- Error code F switches the block to a fixed error blink.

Parameters:
- TICK_DIV, 50000, clk cycles per ms tick (1 ms at 50 MHz).
- PULSE_MS, 100, length in ticks of each of LUB, GAP and DUB.
- PERIOD1, 1000, beat period in ticks for mode 1 (60 bpm).
- PERIOD2, 750, beat period for mode 2 (80 bpm).
- PERIOD3, 500, beat period for mode 3 (120 bpm).
- PERIOD4, 375, beat period for mode 4 (160 bpm).
- ERR_HALF, 250, error blink half-period in ticks.
- DUB_DUTY, 128, DUB brightness as x/256 PWM duty.
- Constraints: every PERIODn >= 3*PULSE_MS+1; all parameters >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_in  in  4  mode code from button latch: 1..4 valid, F error, other values ignored
- led  out  1  heartbeat LED drive, active-high
- beat  out  1  1-cycle pulse on entry to LUB
- cur_mode  out  4  mode code currently governing the heartbeat timing
- err  out  1  high while the block is in an error state

Behaviour:
- Reset (async assert, rst_n low):
  - led=0, beat=0, cur_mode=4'h1, err=0, pending_mode=4'h1.
  - state=REST, ms_cnt=REST_LEN(1)-1, tick_cnt=0, pwm_cnt=0.
  - Reset mid-pattern or mid-error aborts immediately to these values.
- Tick:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-cycle pulse when tick_cnt==TICK_DIV-1.
  - The first tick occurs on the TICK_DIV-th clock after reset release.
- Timing engine:
  - ms_cnt advances only on tick.
  - On tick, if ms_cnt == DUR(state)-1: move to the next state and set ms_cnt=0. Otherwise ms_cnt+1.
  - DUR(LUB)=DUR(GAP)=DUR(DUB)=PULSE_MS.
  - DUR(REST)=REST_LEN(cur_mode)=PERIODm-3*PULSE_MS.
  - DUR(ERR_ON)=DUR(ERR_OFF)=ERR_HALF.
- Heartbeat states: LUB -> GAP -> DUB -> REST -> LUB.
  - On the REST->LUB transition: cur_mode <= pending_mode (value held before that edge), and beat=1 for exactly that one cycle.
  - The first beat after reset coincides with the first tick.
- Mode capture:
  - Any clock with mode_in in 1..4 loads pending_mode.
  - cur_mode changes only at a beat boundary, so a pattern is never truncated.
  - A new code arriving on the same edge as REST->LUB takes effect at the following beat.
  - Codes 0 and 5..E are ignored: pending_mode holds.
- Error entry:
  - mode_in==F in any heartbeat state goes to ERR_ON on the next clock, not waiting for a tick.
  - On entry: ms_cnt=0, err=1, beat=0. pending_mode and cur_mode are unchanged.
- Error states: ERR_ON <-> ERR_OFF, alternating every ERR_HALF ticks.
  - While mode_in==F, the block stays in ERR_ON/ERR_OFF.
  - mode_in in 1..4 loads pending_mode, then goes to REST with ms_cnt=REST_LEN(pending)-1 on the next clock, with err=0.
  - The next tick then gives LUB with beat=1 and cur_mode=the new code.
- PWM and LED:
  - pwm_cnt is an 8-bit free-running counter, +1 every clk, wrapping 255->0.
  - led is registered, one cycle behind the state/pwm:
    - LUB=1
    - DUB=(pwm_cnt<DUB_DUTY)
    - ERR_ON=1
    - GAP, REST, ERR_OFF=0
  - DUB_DUTY=0 gives dark; DUB_DUTY>=256 is illegal.
- Widths:
  - ms_cnt is wide enough for max(PERIODn, ERR_HALF).
  - tick_cnt uses $clog2(TICK_DIV) bits, minimum 1.
  - All compares are unsigned.

Test Plan (TICK_DIV=4, PULSE_MS=3, PERIOD1..4=20/16/12/10, ERR_HALF=5, DUB_DUTY=128):
- Reset release, mode_in=1 held:
  - first beat at clk 4;
  - subsequent beats every 80 clks;
  - led high 12 clks after each beat (1-cycle lag);
  - cur_mode=1, err=0.
- mode_in changed 1->3 mid-GAP:
  - current beat completes at 80-clk spacing;
  - next beat interval 48 clks;
  - cur_mode becomes 3 on that beat cycle.
- mode_in=F mid-DUB:
  - err=1 and led=1 one clock later;
  - led toggles every 20 clks;
  - no beat pulses while in error.
- In error, mode_in=F->4: err=0 next clk, beat at next tick, then beats every 40 clks, cur_mode=4.
- mode_in=7 or 0 during mode 2 operation: no change; beats stay at 64-clk spacing; cur_mode=2.
- rst_n asserted mid-LUB and in ERR_ON: all outputs return to reset values asynchronously; the sequence restarts as in the first scenario.
- Duty check: during DUB with DUB_DUTY=128, led duty over 256 clks = 128/256 ±1.
